// File: rtl/norflash8_wb_pkg.sv
// Shared definitions for the 8-bit NOR flash Wishbone bridge: FSM state
// encodings, the board-level default wait-state count and a counter-width helper.
`timescale 1ns/1ps
package norflash8_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // 7 cycles per byte at 50 MHz = 140 ns, enough for a 110 ns flash.
  localparam int RD_TIMING_DEFAULT = 6;

  function automatic int cnt_width(input int rd_timing);
    return (rd_timing < 1) ? 1 : $clog2(rd_timing + 1);
  endfunction

endpackage

// File: rtl/norflash8_wb.sv
// Read-only Wishbone slave that assembles each 32-bit big-endian word from four
// byte reads of an asynchronous 8-bit NOR flash, spaced by rd_timing wait states.
`timescale 1ns/1ps
module norflash8_wb
  import norflash8_wb_pkg::*;
#(
  parameter int adr_width = 24,
  parameter int rd_timing = RD_TIMING_DEFAULT
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic [adr_width-1:0] flash_adr,
  input  logic [7:0]           flash_d,
  output logic                 flash_ce_n,
  output logic                 flash_oe_n
);

  localparam int             CNT_W  = cnt_width(rd_timing);
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(rd_timing);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             lane_q, lane_d;
  logic [31:0]            dat_q, dat_d;
  logic [adr_width-1:0]   adr_q, adr_d;
  logic                   ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   ack_q, ack_d;

  // Write data, byte selects and address bits outside the flash window are don't-care.
  logic unused_ok;
  assign unused_ok = ^{wb_dat_i, wb_sel_i, wb_adr_i};

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    dat_d   = dat_q;
    adr_d   = adr_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    ack_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (wb_we_i) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
          end else begin
            adr_d   = {wb_adr_i[adr_width-1:2], 2'b00};
            ce_n_d  = 1'b0;
            oe_n_d  = 1'b0;
            cnt_d   = RD_CNT;
            lane_d  = 2'd0;
            state_d = ST_READ;
          end
        end
      end

      ST_READ: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          unique case (lane_q)
            2'd0: dat_d[31:24] = flash_d;
            2'd1: dat_d[23:16] = flash_d;
            2'd2: dat_d[15:8]  = flash_d;
            2'd3: dat_d[7:0]   = flash_d;
          endcase
          if (lane_q == 2'd3) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
          end else begin
            // Only the low two bits step, so a word never carries into the next one.
            adr_d[1:0] = adr_q[1:0] + 2'd1;
            lane_d     = lane_q + 2'd1;
            cnt_d      = RD_CNT;
          end
        end
      end

      ST_ACK: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
      dat_q   <= '0;
      adr_q   <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      dat_q   <= dat_d;
      adr_q   <= adr_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      ack_q   <= ack_d;
    end
  end

  assign wb_dat_o   = dat_q;
  assign wb_ack_o   = ack_q;
  assign flash_adr  = adr_q;
  assign flash_ce_n = ce_n_q;
  assign flash_oe_n = oe_n_q;

endmodule

// File: tb/tb_norflash8_wb.sv
// Self-checking bench for norflash8_wb: 50 MHz clock, 110 ns flash model and a
// word-level reference model of the flash contents.
`timescale 1ns/1ps
module tb_norflash8_wb;

  localparam int RD_LAT = 29;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [23:0] flash_adr;
  logic [7:0]  flash_d;
  logic        flash_ce_n;
  logic        flash_oe_n;

  int checks   = 0;
  int failures = 0;

  always #10 sys_clk = ~sys_clk;

  norflash8_wb dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_i   (wb_sel_i),
    .wb_we_i    (wb_we_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .flash_adr  (flash_adr),
    .flash_d    (flash_d),
    .flash_ce_n (flash_ce_n),
    .flash_oe_n (flash_oe_n)
  );

  // Flash contents: a few fixed bytes, a scrambled pattern elsewhere.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000010: return 8'hDE;
      24'h000011: return 8'hAD;
      24'h000012: return 8'hBE;
      24'h000013: return 8'hEF;
      24'hFFFFFC: return 8'h01;
      24'hFFFFFD: return 8'h02;
      24'hFFFFFE: return 8'h03;
      24'hFFFFFF: return 8'h04;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  // Word the bus should return: four bytes of the aligned word, lowest address first.
  function automatic logic [31:0] exp_word(input logic [31:0] bus_adr);
    logic [23:0] a;
    a = bus_adr[23:0] & 24'hFFFFFC;
    return {flash_byte(a), flash_byte(a + 24'd1), flash_byte(a + 24'd2), flash_byte(a + 24'd3)};
  endfunction

  assign #110 flash_d = (!flash_ce_n && !flash_oe_n) ? flash_byte(flash_adr) : 8'hxx;

  task automatic idle_bus();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  // Issue one request at a negedge, count cycles to ack (bounded), then drop stb.
  task automatic do_access(input logic [31:0] adr, input logic we,
                           output logic [31:0] data, output int lat, output logic extra_ack);
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_dat_i = $urandom;
    wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    lat  = -1;
    data = '0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge sys_clk);
      if (wb_ack_o) begin
        lat  = i;
        data = wb_dat_o;
        break;
      end
    end
    idle_bus();
    @(negedge sys_clk);
    extra_ack = wb_ack_o;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int          lat;
    logic        x;
    sys_rst  = 1'b1;
    wb_adr_i = 32'h0000_0010;
    wb_dat_i = '0;
    wb_sel_i = 4'hF;
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      checks++;
      if ({wb_ack_o, wb_dat_o, flash_adr, flash_ce_n, flash_oe_n} !== {1'b0, 32'h0, 24'h0, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got ack=%b dat=%h adr=%h ce_n=%b oe_n=%b want 0/0/0/1/1",
                 c, wb_ack_o, wb_dat_o, flash_adr, flash_ce_n, flash_oe_n);
      end
    end
    sys_rst = 1'b0;
    wb_cyc_i = 1'b0;
    do_access(32'h0000_0010, 1'b0, d, lat, x);
    checks++;
    if (lat !== RD_LAT) begin
      failures++;
      $display("FAIL reset_release_latency got %0d want %0d", lat, RD_LAT);
    end
    checks++;
    if (d !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL reset_release_data got %h want DEADBEEF", d);
    end
  endtask

  // Cycle-by-cycle trace of one read: address stepping, strobes, ack timing, data.
  task automatic trace_read(input string name, input logic [31:0] adr,
                            input logic [23:0] base, input logic [31:0] exp);
    logic [23:0] ea;
    wb_adr_i = adr;
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge sys_clk);
      if (k <= 28) begin
        ea = base + 24'((k - 1) / 7);
        checks++;
        if ({flash_adr, flash_ce_n, flash_oe_n, wb_ack_o} !== {ea, 3'b000}) begin
          failures++;
          $display("FAIL %s_cycle%0d got adr=%h ce_n=%b oe_n=%b ack=%b want adr=%h 0/0/0",
                   name, k, flash_adr, flash_ce_n, flash_oe_n, wb_ack_o, ea);
        end
      end else if (k == 29) begin
        checks++;
        if ({wb_ack_o, wb_dat_o, flash_ce_n, flash_oe_n} !== {1'b1, exp, 2'b11}) begin
          failures++;
          $display("FAIL %s_ack got ack=%b dat=%h ce_n=%b oe_n=%b want 1/%h/1/1",
                   name, wb_ack_o, wb_dat_o, flash_ce_n, flash_oe_n, exp);
        end
        idle_bus();
      end else begin
        checks++;
        if (wb_ack_o !== 1'b0) begin
          failures++;
          $display("FAIL %s_ack_width got ack=%b want 0", name, wb_ack_o);
        end
      end
    end
  endtask

  task automatic test_basic_read();
    trace_read("read_0x10", 32'h0000_0010, 24'h000010, 32'hDEADBEEF);
  endtask

  task automatic test_top_addr();
    trace_read("read_top", 32'h01FF_FFFE, 24'hFFFFFC, 32'h01020304);
  endtask

  task automatic test_write();
    logic [23:0] adr_before;
    adr_before = flash_adr;
    wb_adr_i = 32'h0000_0020;
    wb_we_i  = 1'b1;
    wb_dat_i = 32'h1234_5678;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({wb_ack_o, flash_ce_n, flash_oe_n, flash_adr} !== {3'b111, adr_before}) begin
      failures++;
      $display("FAIL write_ack got ack=%b ce_n=%b oe_n=%b adr=%h want 1/1/1/%h",
               wb_ack_o, flash_ce_n, flash_oe_n, flash_adr, adr_before);
    end
    idle_bus();
    @(negedge sys_clk);
    checks++;
    if ({wb_ack_o, flash_ce_n, flash_oe_n} !== 3'b011) begin
      failures++;
      $display("FAIL write_after got ack=%b ce_n=%b oe_n=%b want 0/1/1", wb_ack_o, flash_ce_n, flash_oe_n);
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    int          lat;
    logic        x;
    int          acks;
    wb_adr_i = 32'h0000_0010;
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    repeat (10) @(negedge sys_clk);
    idle_bus();
    @(negedge sys_clk);
    checks++;
    if ({flash_ce_n, flash_oe_n, wb_ack_o} !== 3'b110) begin
      failures++;
      $display("FAIL abort_idle got ce_n=%b oe_n=%b ack=%b want 1/1/0", flash_ce_n, flash_oe_n, wb_ack_o);
    end
    acks = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (wb_ack_o) acks++;
    end
    checks++;
    if (acks !== 0) begin
      failures++;
      $display("FAIL abort_no_ack got %0d acks want 0", acks);
    end
    do_access(32'h0000_0010, 1'b0, d, lat, x);
    checks++;
    if ({lat, d} !== {RD_LAT, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL abort_reread got lat=%0d dat=%h want %0d DEADBEEF", lat, d, RD_LAT);
    end
  endtask

  task automatic test_random();
    logic [31:0] adr, d;
    logic        we, x;
    int          lat, exp_lat;
    for (int n = 0; n < 12; n++) begin
      adr = $urandom;
      we  = ($urandom_range(0, 3) == 0);
      exp_lat = we ? 1 : RD_LAT;
      do_access(adr, we, d, lat, x);
      checks++;
      if (lat !== exp_lat) begin
        failures++;
        $display("FAIL rand%0d_latency adr=%h we=%b got %0d want %0d", n, adr, we, lat, exp_lat);
      end
      if (!we) begin
        checks++;
        if (d !== exp_word(adr)) begin
          failures++;
          $display("FAIL rand%0d_data adr=%h got %h want %h", n, adr, d, exp_word(adr));
        end
      end
      checks++;
      if (x !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_ack_width got second ack=%b want 0", n, x);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   t_first, t_second, cyc, acks;
    logic [31:0] d0, d1;
    wb_adr_i = 32'h0000_0000;
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    t_first = -1;
    t_second = -1;
    d0 = '0;
    d1 = '0;
    cyc = 0;
    while (cyc < 120 && t_second < 0) begin
      @(negedge sys_clk);
      cyc++;
      if (wb_ack_o) begin
        if (t_first < 0) begin
          t_first = cyc;
          d0 = wb_dat_o;
          idle_bus();
          @(negedge sys_clk);
          cyc++;
          wb_adr_i = 32'h0000_0004;
          wb_cyc_i = 1'b1;
          wb_stb_i = 1'b1;
        end else begin
          t_second = cyc;
          d1 = wb_dat_o;
          idle_bus();
        end
      end
    end
    idle_bus();
    checks++;
    if (t_second - t_first !== 30 || t_first < 0) begin
      failures++;
      $display("FAIL b2b_spacing got first=%0d second=%0d want 30 apart", t_first, t_second);
    end
    checks++;
    if ({d0, d1} !== {exp_word(32'h0), exp_word(32'h4)}) begin
      failures++;
      $display("FAIL b2b_data got %h %h want %h %h", d0, d1, exp_word(32'h0), exp_word(32'h4));
    end

    @(negedge sys_clk);
    wb_adr_i = 32'h0000_0004;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    repeat (15) @(negedge sys_clk);
    sys_rst = 1'b1;
    idle_bus();
    @(negedge sys_clk);
    checks++;
    if ({wb_ack_o, wb_dat_o, flash_adr, flash_ce_n, flash_oe_n} !== {1'b0, 32'h0, 24'h0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL midread_reset got ack=%b dat=%h adr=%h ce_n=%b oe_n=%b want 0/0/0/1/1",
               wb_ack_o, wb_dat_o, flash_adr, flash_ce_n, flash_oe_n);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    acks = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (wb_ack_o || !flash_oe_n || !flash_ce_n) acks++;
    end
    checks++;
    if (acks !== 0) begin
      failures++;
      $display("FAIL midread_no_ack got %0d active cycles want 0", acks);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_write();
    test_abort();
    test_top_addr();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/norflash8_wb.md
Name: norflash8_wb

Overview:
- Read-only Wishbone slave bridging the 32-bit system bus to an 8-bit asynchronous parallel NOR flash (boot/BIOS ROM).
- Drives flash_adr and flash_oe_n/flash_ce_n, and samples flash_d. Each 32-bit word is assembled from four byte reads, spaced by a programmable wait-state count.
- Sits between the CPU instruction/data bus arbiter and the board flash pins.

Parameters:
- adr_width, 24, flash byte-address width (flash_adr width).
- rd_timing, 6, extra wait cycles per byte before sampling flash_d. Each byte takes rd_timing+1 cycles: 140 ns at 50 MHz, which covers a 110 ns access time.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous reset, active-high
- wb_adr_i  in  32  byte address; bits [1:0] ignored, bits above adr_width-1 ignored
- wb_dat_i  in  32  write data (ignored)
- wb_sel_i  in  4  byte select (ignored; full word always read)
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_dat_o  out  32  read data, big-endian (byte at lowest address in [31:24])
- wb_ack_o  out  1  single-cycle acknowledge
- flash_adr  out  adr_width  flash byte address
- flash_d  in  8  flash data
- flash_ce_n  out  1  chip enable, active-low
- flash_oe_n  out  1  output enable, active-low

Behaviour:
- All outputs are registered. Reset (sync, any state): state=IDLE, wb_ack_o=0, wb_dat_o=0, flash_adr=0, flash_ce_n=1, flash_oe_n=1, counter=0, lane=0.
- States: IDLE, READ, ACK.
- IDLE:
  - cyc&stb&!we seen in cycle N: at the end of N, flash_adr={wb_adr_i[adr_width-1:2],2'b00}, ce_n=0, oe_n=0, counter=rd_timing, lane=0, go READ.
  - cyc&stb&we: go ACK. There is no flash activity and flash pins stay idle.
- READ, each cycle:
  - If !wb_cyc_i: abort, go IDLE, ce_n=oe_n=1, no ack, wb_dat_o unchanged.
  - Else if counter!=0: counter-1.
  - Else (counter==0): latch flash_d into wb_dat_o lane (lane0→[31:24] … lane3→[7:0]).
    - If lane==3: go ACK, ce_n=oe_n=1.
    - Else: flash_adr[1:0]+1, lane+1, counter=rd_timing.
- ACK: wb_ack_o=1 for exactly this cycle, then IDLE with ack=0.
  - Master drops stb at the ack edge, so the next IDLE cycle sees only new requests.
- Latency:
  - Read accepted in cycle N → ack high in cycle N+1+4*(rd_timing+1), i.e. N+29 at default.
  - Write accepted in cycle N → ack high in cycle N+1.
- flash_adr is stable for rd_timing+1 cycles before each sample.
- flash_adr holds its last value in IDLE.
- Byte-lane updates in wb_dat_o are visible mid-read. The value is only valid with ack.
- rd_timing=0: one cycle per byte; a read acks at N+5.
- Counter width is clog2(rd_timing+1), minimum 1 bit.
- Address wrap: lane increment touches only flash_adr[1:0] and never carries.

Decomposition:
- Shared header norflash.vh: state encodings (IDLE=2'd0, READ=2'd1, ACK=2'd2) and the default rd_timing constant for board top-levels.
- Sub-module: none required. The wait counter is small enough to stay inline.

Test Plan:
- Hold sys_rst for 3 cycles while cyc/stb are asserted → all outputs at reset values, no ack. After release, ack follows the normal read latency.
- Flash model with 110 ns access delay, bytes 0x10..0x13 = DE AD BE EF. Read wb_adr_i=0x00000010 → flash_adr steps 0x10,0x11,0x12,0x13, each held 7 cycles. wb_dat_o=0xDEADBEEF with single-cycle ack at N+29. oe_n/ce_n low from N+1 through N+28.
- Write to 0x00000020 with we=1 → ack at N+1, flash_ce_n/oe_n stay 1, flash_adr unchanged.
- Start a read, drop wb_cyc_i at N+10 → no ack ever, state IDLE by N+11, oe_n=1. A following read of 0x10 returns 0xDEADBEEF correctly.
- Read wb_adr_i=0x01FFFFFE, flash top bytes = 01 02 03 04 → flash_adr 0xFFFFFC..0xFFFFFF, wb_dat_o=0x01020304, no wrap to 0x000000.
- Back-to-back reads of 0x0 and 0x4, second stb asserted the cycle after ack → two acks exactly 30 cycles apart. Assert sys_rst mid-second-read → second ack never appears, outputs return to reset values.
